fifo_write_arbiter: RTL

Two-writer, one-reader controller for the 4-entry byte FIFO between the host link receivers and the transmit path. Each cycle it grants at most one of two producer ports in round-robin order, owns the storage, read/write pointers and occupancy count, and presents the head entry to a single consumer through a valid/ready handshake. Occupancy saturates at 0 and DEPTH, matching the pointer convention used elsewhere in the FIFO path. Writes are refused when full and reads are refused when empty.

---
 rtl/fifo_write_arbiter_pkg.sv | 27 ++
 rtl/fifo_write_arbiter_rr_arbiter2.sv | 38 +++
 rtl/fifo_write_arbiter.sv | 91 +++++++++
 3 files changed

// File: rtl/fifo_write_arbiter_pkg.sv
// Shared sizing constants and port-identifier type for the two-writer byte FIFO.
// Also holds the pure round-robin selection function used by the arbiter.
package fifo_pkg;

  localparam int unsigned FIFO_DEPTH  = 4;
  localparam int unsigned FIFO_DATA_W = 8;
  localparam int unsigned LEVEL_W     = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  // One-hot pick among two requesters; on contention the port that did not win last time goes.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input port_e last);
    logic [1:0] g;
    g = '0;
    case (req)
      2'b01:   g = 2'b01;
      2'b10:   g = 2'b10;
      2'b11:   g = (last == PORT1) ? 2'b01 : 2'b10;
      default: g = '0;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_arbiter2.sv
// Two-request round-robin arbiter with its own last-grant history register.
// Grants nothing while reset is asserted or the enable is low.
module rr_arbiter2
  import fifo_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  port_e last_q;
  port_e last_d;

  always_comb begin
    gnt    = '0;
    last_d = last_q;
    if (!rst && en) begin
      gnt = rr_pick(req, last_q);
      if (gnt[0]) begin
        last_d = PORT0;
      end else if (gnt[1]) begin
        last_d = PORT1;
      end
    end
  end

  // Reset history to port 1 so port 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= PORT1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Two-producer, one-consumer byte FIFO: round-robin write grant, storage, pointers and
// saturating occupancy, with the head entry presented on a valid/ready read port.
module fifo_write_arbiter
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = FIFO_DATA_W,
  parameter int unsigned DEPTH  = FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req0_valid,
  input  logic [DATA_W-1:0]        req0_data,
  output logic                     req0_ready,
  input  logic                     req1_valid,
  input  logic [DATA_W-1:0]        req1_data,
  output logic                     req1_ready,
  output logic                     rd_valid,
  output logic [DATA_W-1:0]        rd_data,
  input  logic                     rd_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [1:0]        gnt;
  logic              wr_fire;
  logic              rd_fire;
  logic [DATA_W-1:0] wr_data;

  // Full is taken from registered level, so a same-cycle read never frees a slot for a write.
  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;

  rr_arbiter2 u_arb (
    .clk (clk),
    .rst (rst),
    .en  (!full),
    .req ({req1_valid, req0_valid}),
    .gnt (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  assign rd_valid = !empty;
  assign rd_data  = mem_q[rd_ptr_q];

  always_comb begin
    wr_fire  = |gnt;
    rd_fire  = rd_ready && !empty && !rst;
    wr_data  = gnt[1] ? req1_data : req0_data;
    wr_ptr_d = wr_fire ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_fire ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    case ({wr_fire, rd_fire})
      2'b10: if (level_q != LVL_W'(DEPTH)) level_d = level_q + LVL_W'(1);
      2'b01: if (level_q != '0)            level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  a_one_grant: assert property (@(posedge clk) !(req0_ready && req1_ready));
  a_level_max: assert property (@(posedge clk) disable iff (rst) level_q <= LVL_W'(DEPTH));

endmodule
